dmem_lsu: RTL and testbench

Load/store unit that acts as the initiator on the data-memory port: it accepts one load or store request at a time from the core, drives the word-addressed, asynchronous-read/synchronous-write data memory, and returns a response. Sub-word stores (SB/SH) are done as two-cycle read-modify-write sequences because the memory only writes whole words. Sub-word loads are extracted and sign- or zero-extended. It sits between the datapath's memory stage and the data memory; the core stalls while `req_ready` is low.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane.sv | 37 +++
 rtl/dmem_lsu.sv | 119 +++++++++++
 tb/tb_dmem_lsu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Opcode encoding and FSM state constants are used by both the FSM and the datapath lane.
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        SW  = 3'd3,
        LBU = 3'd4,
        LHU = 3'd5,
        SB  = 3'd6,
        SH  = 3'd7
    } lsu_op_t;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE   = 3'd0;
    localparam lsu_state_t ST_LOAD   = 3'd1;
    localparam lsu_state_t ST_RMW_RD = 3'd2;
    localparam lsu_state_t ST_WRITE  = 3'd3;
    localparam lsu_state_t ST_RESP   = 3'd4;

    function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] addr_lo);
        case (op)
            LH, LHU, SH: return addr_lo[0];
            LW, SW:      return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input lsu_op_t op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
// Little-endian: byte k lives in bits [8k+7:8k].
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  lsu_op_t     op,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{addr_lo, 3'b000} +: 8];
        half_v = word[{addr_lo[1], 4'b0000} +: 16];

        case (op)
            LB:      load_data = {{24{byte_v[7]}}, byte_v};
            LBU:     load_data = {24'd0, byte_v};
            LH:      load_data = {{16{half_v[15]}}, half_v};
            LHU:     load_data = {16'd0, half_v};
            default: load_data = word;
        endcase

        merged = word;
        case (op)
            SB:      merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            SH:      merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-addressed async-read / sync-write data memory.
// One transaction at a time; sub-word stores run as read-modify-write.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
);

    lsu_state_t        state_q, state_d;
    lsu_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0] lane_load;
    logic [31:0] lane_merged;
    lsu_op_t     req_op_t;

    assign req_op_t = lsu_op_t'(req_op);

    lsu_lane u_lane (
        .word      (mem_readdata),
        .addr_lo   (addr_q[1:0]),
        .op        (op_q),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op_t;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    merge_d = req_wdata;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    if (is_misaligned(req_op_t, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (is_load(req_op_t)) begin
                        state_d = ST_LOAD;
                    end else if (req_op_t == SW) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = lane_load;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                merge_d = lane_merged;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= LB;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            merge_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory strobes are decoded straight from state so a WRITE cycle always commits.
    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign mem_we        = (state_q == ST_WRITE);
    assign mem_writedata = (state_q == ST_WRITE) ? merge_q : 32'd0;
    assign mem_addr      = (state_q == ST_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed test-plan steps followed by random
// traffic, checked against a byte-mask reference model of the memory.
module tb_dmem_lsu;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'd0;
    int          we_cnt = 0;
    int          cyc_cnt = 0;
    int          last_we_cyc = 0;
    logic [31:0] last_we_addr = 32'd0;
    logic [31:0] last_we_data = 32'd0;

    localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_SW = 3'd3,
                           OP_LBU = 3'd4, OP_LHU = 3'd5, OP_SB = 3'd6, OP_SH = 3'd7;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
    );

    assign mem_readdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_writedata;
            we_cnt       <= we_cnt + 1;
            last_we_cyc  <= cyc_cnt;
            last_we_addr <= mem_addr;
            last_we_data <= mem_writedata;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = idx[5:0];
        pre_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Reference: size/alignment/extension from plain arithmetic on the byte address.
    task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd);
        int          size, sh, idx, cyc, acc_cyc, we_base, exp_lat, exp_wr;
        logic        is_ld, exp_err;
        logic [31:0] v, mask, exp_rd, exp_word;
        size  = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
                (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
        is_ld = (op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU);
        idx   = int'(addr / 4) % 64;
        sh    = 8 * int'(addr % 4);
        exp_err  = (addr % size) != 0;
        exp_rd   = 32'd0;
        exp_wr   = 0;
        exp_word = ref_mem[idx];
        if (exp_err) begin
            exp_lat = 1;
        end else if (is_ld) begin
            exp_lat = 2;
            v = ref_mem[idx] >> sh;
            if (size == 1) begin
                v = v % 256;
                if (op == OP_LB && v >= 128) v = v + 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v % 65536;
                if (op == OP_LH && v >= 32768) v = v + 32'hFFFF_0000;
            end
            exp_rd = v;
        end else begin
            exp_lat = (size == 4) ? 2 : 3;
            exp_wr  = 1;
            mask = (size == 4) ? 32'hFFFF_FFFF : ((size == 2) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
            exp_word = (ref_mem[idx] & ~mask) | ((wdata << sh) & mask);
        end

        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        we_base   = we_cnt;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        acc_cyc   = 0;
        cyc       = 0;
        rd        = 32'd0;
        while (cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid = 1'b0;
                acc_cyc   = cyc_cnt - 1;
                chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
            end
            if (resp_valid) break;
        end
        rd = resp_rdata;
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_resp_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_nwrites"}, we_cnt - we_base, exp_wr);
        if (exp_wr == 1) begin
            chk({tag, "_wcyc"}, last_we_cyc - acc_cyc, exp_lat - 1);
            chk({tag, "_wdata"}, last_we_data, exp_word);
            chk({tag, "_waddr"}, last_we_addr, addr & 32'hFFFF_FFFC);
        end
        ref_mem[idx] = exp_word;
        chk({tag, "_mem"}, mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  op;
        logic [31:0] addr;
        int          we_base;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);

        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_writedata, 32'd0);
        reset = 1'b0;

        preload(4, 32'hA1B2_C3D4);
        preload(5, 32'h0000_0000);
        preload(8, 32'h1234_5678);

        do_req("lw10", OP_LW, 32'h10, 32'd0, rd);
        chk("lw10_const", rd, 32'hA1B2_C3D4);
        do_req("lb13", OP_LB, 32'h13, 32'd0, rd);
        chk("lb13_const", rd, 32'hFFFF_FFA1);
        do_req("lbu13", OP_LBU, 32'h13, 32'd0, rd);
        chk("lbu13_const", rd, 32'h0000_00A1);
        do_req("lh12", OP_LH, 32'h12, 32'd0, rd);
        chk("lh12_const", rd, 32'hFFFF_A1B2);
        do_req("lhu12", OP_LHU, 32'h12, 32'd0, rd);
        chk("lhu12_const", rd, 32'h0000_A1B2);
        do_req("sb11", OP_SB, 32'h11, 32'h0000_0055, rd);
        chk("sb11_word", mem[4], 32'hA1B2_55D4);
        do_req("lw10b", OP_LW, 32'h10, 32'd0, rd);
        chk("lw10b_const", rd, 32'hA1B2_55D4);
        do_req("sh16", OP_SH, 32'h16, 32'h0000_BEEF, rd);
        chk("sh16_word", mem[5], 32'hBEEF_0000);
        do_req("sw18", OP_SW, 32'h18, 32'hCAFE_F00D, rd);
        chk("sw18_word", mem[6], 32'hCAFE_F00D);
        do_req("lw12_mis", OP_LW, 32'h12, 32'd0, rd);
        do_req("sh13_mis", OP_SH, 32'h13, 32'h0000_1234, rd);
        chk("sh13_mem", mem[4], 32'hA1B2_55D4);

        // Reset lands while the SB is in its read phase: nothing may be written.
        @(negedge clk);
        we_base   = we_cnt;
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 32'h20;
        req_wdata = 32'h0000_00EE;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rmw_rst_resp", {31'd0, resp_valid}, 32'd0);
        chk("rmw_rst_addr", mem_addr, 32'd0);
        repeat (3) @(negedge clk);
        chk("rmw_rst_nwrites", we_cnt - we_base, 32'd0);
        chk("rmw_rst_word", mem[8], 32'h1234_5678);
        do_req("lw20", OP_LW, 32'h20, 32'd0, rd);
        chk("lw20_const", rd, 32'h1234_5678);

        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 2) == 0) addr = addr + 32'($urandom_range(1, 3));
            do_req("rnd", op, addr, $urandom, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
